// File: rtl/servopwm_pkg.sv
// servopwm_pkg: constants, FSM state type and angle clamp helper shared by
// the servo PWM generator and the servopwm_rx decoder.
//   M          - clock cycles per tick (12 MHz clock -> 7.83 us tick)
//   OFFSET     - high-time ticks that encode angle 0
//   MAX_ANGLE  - largest angle that can be encoded or decoded
//   TICK_PERIOD_NS - nominal tick period, for reference
package servopwm_pkg;

  localparam int unsigned M              = 94;
  localparam int unsigned OFFSET         = 46;
  localparam int unsigned MAX_ANGLE      = 180;
  localparam int unsigned TICK_PERIOD_NS = 7833;

  typedef enum logic [1:0] {
    WAIT_LOW,
    WAIT_RISE,
    MEASURE,
    EMIT
  } state_t;

  // Clamp a signed difference into 0..max_angle.
  function automatic logic [7:0] clamp_angle(input logic signed [9:0] diff,
                                             input logic [7:0]        max_angle);
    if (diff < 0)
      return '0;
    else if (diff > $signed({2'b00, max_angle}))
      return max_angle;
    else
      return diff[7:0];
  endfunction

endpackage

// File: rtl/servopwm_tick.sv
// servopwm_tick: free-running mod-M divider producing a one-cycle tick every
// M clocks; the first tick appears M clocks after reset release.
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   tick  - one-cycle strobe every M clocks
module servopwm_tick #(
  parameter int unsigned M = servopwm_pkg::M
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] LAST = CW'(M - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/servopwm_rx.sv
// servopwm_rx: servo PWM decoder. Measures the high time of pwm_in in ticks,
// validates it and converts it to an 8-bit angle command.
//   clk    - system clock (12 MHz)
//   rst_n  - asynchronous active-low reset
//   pwm_in - PWM line, asynchronous to clk
//   angle  - last accepted angle (resets to HOME_POS)
//   valid  - one-cycle strobe when angle updates
//   err    - one-cycle strobe when a pulse is rejected
//   lost   - no accepted pulse within TIMEOUT ticks (resets to 1)
// Build option: define SERVOPWM_RX_DEGLITCH_EN to insert a 3-sample majority
// filter after the synchronizer (adds 2 clocks of latency).
module servopwm_rx #(
  parameter int unsigned M         = servopwm_pkg::M,
  parameter int unsigned OFFSET    = servopwm_pkg::OFFSET,
  parameter int unsigned MAX_ANGLE = servopwm_pkg::MAX_ANGLE,
  parameter int unsigned MIN_WIDTH = 30,
  parameter int unsigned MAX_WIDTH = 400,
  parameter int unsigned TIMEOUT   = 4096,
  parameter int unsigned HOME_POS  = 90
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwm_in,
  output logic [7:0] angle,
  output logic       valid,
  output logic       err,
  output logic       lost
);

  import servopwm_pkg::*;

  localparam int unsigned   TW   = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO   = TW'(TIMEOUT);
  localparam logic [8:0]    MINW = 9'(MIN_WIDTH);
  localparam logic [8:0]    MAXW = 9'(MAX_WIDTH);

  logic tick;

  servopwm_tick #(.M(M)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // Input conditioning. The chain resets to 1 so that WAIT_LOW only leaves
  // after a genuinely observed low level, never on reset-state zeros.
  logic sync1, sync2, lvl, lvl_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
    end
  end

`ifdef SERVOPWM_RX_DEGLITCH_EN
  logic [1:0] hist;
  logic       filt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '1;
      filt <= 1'b1;
    end else begin
      hist <= {hist[0], sync2};
      filt <= (sync2 & hist[0]) | (sync2 & hist[1]) | (hist[0] & hist[1]);
    end
  end

  assign lvl = filt;
`else
  assign lvl = sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lvl_d <= 1'b1;
    else
      lvl_d <= lvl;
  end

  logic rise, fall;
  assign rise = lvl & ~lvl_d;
  assign fall = ~lvl & lvl_d;

  // Measurement FSM
  state_t     state_q, state_d;
  logic [8:0] width_q, width_d;
  logic       accept, reject;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_LOW;
      width_q <= '0;
    end else begin
      state_q <= state_d;
      width_q <= width_d;
    end
  end

  always_comb begin
    state_d = state_q;
    width_d = width_q;
    accept  = 1'b0;
    reject  = 1'b0;
    case (state_q)
      WAIT_LOW: begin
        if (!lvl) state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (rise) begin
          width_d = '0;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (width_q >= MAXW) begin
          reject  = 1'b1;
          state_d = WAIT_LOW;
        end else if (fall) begin
          state_d = EMIT;
        end else if (tick && lvl && (width_q != '1)) begin
          width_d = width_q + 9'd1;
        end
      end
      EMIT: begin
        state_d = WAIT_RISE;
        if (width_q < MINW) reject = 1'b1;
        else                accept = 1'b1;
      end
      default: state_d = WAIT_LOW;
    endcase
  end

  logic signed [9:0] diff;
  assign diff = $signed({1'b0, width_q}) - $signed(10'(OFFSET));

  // Outputs and loss-of-signal timer
  logic [TW-1:0] tcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      angle <= 8'(HOME_POS);
      valid <= 1'b0;
      err   <= 1'b0;
      lost  <= 1'b1;
      tcnt  <= '0;
    end else begin
      valid <= accept;
      err   <= reject;
      if (accept)
        angle <= clamp_angle(diff, 8'(MAX_ANGLE));

      if (accept)
        tcnt <= '0;
      else if (tick && (tcnt != TO))
        tcnt <= tcnt + TW'(1);

      if (accept)
        lost <= 1'b0;
      else if (tcnt == TO)
        lost <= 1'b1;
    end
  end

endmodule

// File: tb/tb_servopwm_rx.sv
// Directed bench for servopwm_rx with a shortened tick (M=4).
module tb_servopwm_rx;

  localparam int unsigned M = 4;
`ifdef SERVOPWM_RX_DEGLITCH_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwm_in = 1'b0;
  logic [7:0] angle;
  logic       valid, err, lost;

  int errors = 0;
  int checks = 0;
  int vcnt = 0;
  int ecnt = 0;
  int v0, e0;

  servopwm_rx #(.M(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pwm_in(pwm_in),
    .angle (angle),
    .valid (valid),
    .err   (err),
    .lost  (lost)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) vcnt++;
    if (err)   ecnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input logic [31:0] obs,
                           input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Drive a high pulse of 'ticks' ticks, then check the exact strobe latency.
  task automatic pulse(input string tag, input int ticks, input bit exp_ok);
    @(posedge clk); #1 pwm_in = 1'b1;
    repeat (ticks * M) @(posedge clk);
    #1 pwm_in = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    #1 check({tag, "_pre"}, {30'd0, valid, err}, 32'd0);
    @(posedge clk);
    #1 check({tag, "_strobe"}, {30'd0, valid, err}, exp_ok ? 32'd2 : 32'd1);
  endtask

  initial begin
    // Reset state
    idle(3);
    #1;
    check("rst_angle", angle, 90);
    check("rst_valid", valid, 0);
    check("rst_err", err, 0);
    check("rst_lost", lost, 1);
    rst_n = 1'b1;
    idle(12);

    // Nominal: 136 ticks -> 90, two frames
    pulse("nom1", 136, 1'b1);
    check_rng("nom1_angle", angle, 89, 91);
    check("nom1_lost", lost, 0);
    idle(7600);
    pulse("nom2", 136, 1'b1);
    check_rng("nom2_angle", angle, 89, 91);
    idle(20);

    // Clamp low, reject short, clamp high
    pulse("w40", 40, 1'b1);
    check("w40_angle", angle, 0);
    idle(20);
    pulse("w20", 20, 1'b0);
    idle(2);
    check("w20_angle", angle, 0);
    idle(20);
    pulse("w300", 300, 1'b1);
    check("w300_angle", angle, 180);
    idle(20);

    // Stuck high for 500 ticks
    v0 = vcnt; e0 = ecnt;
    @(posedge clk); #1 pwm_in = 1'b1;
    repeat (390 * M) @(posedge clk);
    #1 check("stuck_err_early", ecnt - e0, 0);
    repeat (20 * M) @(posedge clk);
    #1 check("stuck_err_at400", ecnt - e0, 1);
    repeat (90 * M) @(posedge clk);
    #1 pwm_in = 1'b0;
    idle(20);
    #1;
    check("stuck_err_total", ecnt - e0, 1);
    check("stuck_no_valid", vcnt - v0, 0);
    check("stuck_angle", angle, 180);
    idle(20);
    pulse("post_stuck", 136, 1'b1);
    check_rng("post_stuck_angle", angle, 89, 91);

    // Timeout after an accepted pulse
    repeat (4090 * M) @(posedge clk);
    #1 check("to_lost_early", lost, 0);
    repeat (10 * M) @(posedge clk);
    #1 check("to_lost_set", lost, 1);
    check_rng("to_angle_held", angle, 89, 91);
    pulse("to_recover", 91, 1'b1);
    check_rng("to_recover_angle", angle, 44, 46);
    check("to_recover_lost", lost, 0);
    idle(20);

    // Reset in the middle of a pulse, released while still high
    @(posedge clk); #1 pwm_in = 1'b1;
    repeat (50 * M) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_angle", angle, 90);
    check("mid_rst_lost", lost, 1);
    idle(3);
    #1 rst_n = 1'b1;
    v0 = vcnt; e0 = ecnt;
    repeat (50 * M) @(posedge clk);
    #1 pwm_in = 1'b0;
    idle(20);
    #1;
    check("mid_rst_no_valid", vcnt - v0, 0);
    check("mid_rst_no_err", ecnt - e0, 0);
    check("mid_rst_angle_after", angle, 90);
    idle(20);
    pulse("mid_rst_next", 106, 1'b1);
    check_rng("mid_rst_next_angle", angle, 59, 61);
    idle(20);

    // Single-clock spikes on a low line
    v0 = vcnt; e0 = ecnt;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 pwm_in = 1'b1;
      @(posedge clk); #1 pwm_in = 1'b0;
      idle(30);
    end
    #1;
`ifdef SERVOPWM_RX_DEGLITCH_EN
    check("spike_err", ecnt - e0, 0);
`else
    check("spike_err", ecnt - e0, 3);
`endif
    check("spike_no_valid", vcnt - v0, 0);
    check_rng("spike_angle", angle, 59, 61);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
